// File: rtl/vga_vram_write_ctrl.sv
// rtl/vga_vram_write_ctrl.sv - VRAM write-port arbiter, fill engine, tear-free scroll and frame counter
module vga_vram_write_ctrl #(
    parameter int DEPTH         = 4096,
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int OFFSET_WIDTH  = 10,
    parameter int FILL_ON_VSYNC = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_din,
    input  logic                    cpu_we,
    input  logic                    fill_start,
    input  logic [DATA_WIDTH-1:0]   fill_color,
    output logic                    fill_busy,
    output logic                    fill_done,
    input  logic [OFFSET_WIDTH-1:0] scroll_h_in,
    input  logic [OFFSET_WIDTH-1:0] scroll_v_in,
    input  logic                    scroll_we,
    input  logic                    vsync,
    output logic [31:0]             data_address,
    output logic [DATA_WIDTH-1:0]   data_din,
    output logic                    data_we,
    output logic [31:0]             offset_h,
    output logic [31:0]             offset_v,
    output logic [15:0]             frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FILL
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   fill_addr;
    logic [DATA_WIDTH-1:0]   fill_color_q;
    logic [OFFSET_WIDTH-1:0] shadow_h;
    logic [OFFSET_WIDTH-1:0] shadow_v;
    logic                    vsync_prev;
    logic                    vs_edge;
    logic                    accept;
    logic                    fill_issue;
    logic                    fill_last;
    logic                    last_issued;

    assign vs_edge = vsync_prev & ~vsync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CPU has fixed priority: a cpu_we cycle simply withholds the fill issue.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        fill_issue = 1'b0;
        fill_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fill_start) begin
                    accept    = 1'b1;
                    state_nxt = (FILL_ON_VSYNC != 0) ? S_ARM : S_FILL;
                end
            end
            S_ARM: begin
                if (vs_edge) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (!cpu_we) begin
                    fill_issue = 1'b1;
                    if (fill_addr == LAST_ADDR) begin
                        fill_last = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_addr    <= '0;
            fill_color_q <= '0;
            fill_busy    <= 1'b0;
            last_issued  <= 1'b0;
            fill_done    <= 1'b0;
        end else begin
            if (accept) begin
                fill_addr    <= '0;
                fill_color_q <= fill_color;
            end else if (fill_issue) begin
                fill_addr <= fill_addr + 1'b1;
            end
            if (accept) begin
                fill_busy <= 1'b1;
            end else if (fill_last) begin
                fill_busy <= 1'b0;
            end
            // Two-stage so the done pulse trails the last visible fill write.
            last_issued <= fill_last;
            fill_done   <= last_issued;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_address <= '0;
            data_din     <= '0;
            data_we      <= 1'b0;
        end else if (cpu_we) begin
            data_address <= 32'(cpu_address);
            data_din     <= cpu_din;
            data_we      <= 1'b1;
        end else if (fill_issue) begin
            data_address <= 32'(fill_addr);
            data_din     <= fill_color_q;
            data_we      <= 1'b1;
        end else begin
            data_we <= 1'b0;
        end
    end

    // Offsets only move at vsync start; a same-cycle scroll_we bypasses the shadows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev  <= 1'b1;
            shadow_h    <= '0;
            shadow_v    <= '0;
            offset_h    <= '0;
            offset_v    <= '0;
            frame_count <= '0;
        end else begin
            vsync_prev <= vsync;
            if (scroll_we) begin
                shadow_h <= scroll_h_in;
                shadow_v <= scroll_v_in;
            end
            if (vs_edge) begin
                offset_h    <= 32'(scroll_we ? scroll_h_in : shadow_h);
                offset_v    <= 32'(scroll_we ? scroll_v_in : shadow_v);
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
